// File: rtl/chacha_stream_ctrl.sv
// Multi-block keystream sequencer in front of chacha_core: one init, then next pulses, blocks out over valid/ready.
// Optional watchdog on the core wait states is enabled by defining CHACHA_CTRL_TIMEOUT_EN.
module chacha_stream_ctrl #(
  parameter int unsigned NB_W    = 16,
  parameter int unsigned ROUNDS  = 20,
  parameter int unsigned TMO_CYC = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [255:0]      key_in,
  input  logic [63:0]       iv_in,
  input  logic [63:0]       ctr_in,
  input  logic [NB_W-1:0]   num_blocks,
  output logic              busy,
  output logic              done,
  output logic              ctr_wrap,
  output logic              err_timeout,
  output logic [511:0]      ks_data,
  output logic [63:0]       ks_ctr,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              core_init,
  output logic              core_next,
  output logic [255:0]      core_key,
  output logic [63:0]       core_iv,
  output logic [63:0]       core_ctr,
  output logic              core_keylen,
  output logic [4:0]        core_rounds,
  input  logic              core_ready,
  input  logic              core_data_out_valid,
  input  logic [511:0]      core_data_out
);

  localparam int unsigned CTR_W  = 64;
  localparam int unsigned RND_W  = 5;
  localparam int unsigned WD_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WLO,
    S_WHI,
    S_HOLD
  } state_t;

  state_t            state;
  logic [NB_W-1:0]   left;
  logic [CTR_W-1:0]  cur_ctr;
  logic              first;
  logic              capture_c;
  logic              wd_hit_c;

  assign core_keylen = 1'b1;
  assign core_rounds = RND_W'(ROUNDS);

  assign capture_c = (state == S_WHI) && core_ready && core_data_out_valid;

`ifdef CHACHA_CTRL_TIMEOUT_EN
  logic [WD_W-1:0] wdog;

  // Counts cycles spent waiting on the core for the current block; HOLD is never counted.
  assign wd_hit_c = ((state == S_WLO) || (state == S_WHI)) && !capture_c &&
                    (wdog == WD_W'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wd_hit_c && !abort;
      if ((state == S_WLO) || (state == S_WHI)) begin
        wdog <= wdog + WD_W'(1);
      end else begin
        wdog <= '0;
      end
    end
  end
`else
  assign wd_hit_c    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Job sequencer; abort overrides every state, reset overrides abort.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ctr_wrap  <= 1'b0;
      ks_data   <= '0;
      ks_ctr    <= '0;
      ks_valid  <= 1'b0;
      core_init <= 1'b0;
      core_next <= 1'b0;
      core_key  <= '0;
      core_iv   <= '0;
      core_ctr  <= '0;
      left      <= '0;
      cur_ctr   <= '0;
      first     <= 1'b0;
    end else begin
      done      <= 1'b0;
      core_init <= 1'b0;
      core_next <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        ks_valid <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              if (num_blocks == '0) begin
                done <= 1'b1;
              end else if (core_ready) begin
                core_key <= key_in;
                core_iv  <= iv_in;
                core_ctr <= ctr_in;
                cur_ctr  <= ctr_in;
                left     <= num_blocks;
                first    <= 1'b1;
                ctr_wrap <= 1'b0;
                busy     <= 1'b1;
                state    <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            if (core_ready) begin
              core_init <= first;
              core_next <= !first;
              first     <= 1'b0;
              state     <= S_WLO;
            end
          end
          S_WLO: begin
            // A valid still high from the previous block must not be taken; wait for the core to go busy.
            if (wd_hit_c) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (!core_ready) begin
              state <= S_WHI;
            end
          end
          S_WHI: begin
            if (capture_c) begin
              ks_data  <= core_data_out;
              ks_ctr   <= cur_ctr;
              ks_valid <= 1'b1;
              state    <= S_HOLD;
            end else if (wd_hit_c) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_HOLD: begin
            if (ks_ready) begin
              ks_valid <= 1'b0;
              left     <= left - NB_W'(1);
              cur_ctr  <= cur_ctr + CTR_W'(1);
              if (&cur_ctr) begin
                ctr_wrap <= 1'b1;
              end
              if (left == NB_W'(1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                state <= S_ISSUE;
              end
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Self-checking bench for chacha_stream_ctrl with a behavioural chacha_core stand-in and block scoreboard.
// Honours CHACHA_CTRL_TIMEOUT_EN for the stalled-core scenario.
module tb_chacha_stream_ctrl;
  localparam int unsigned NB_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [255:0]      key_in = '0;
  logic [63:0]       iv_in = '0;
  logic [63:0]       ctr_in = '0;
  logic [NB_W-1:0]   num_blocks = '0;
  logic              busy, done, ctr_wrap, err_timeout;
  logic [511:0]      ks_data;
  logic [63:0]       ks_ctr;
  logic              ks_valid, ks_ready;
  logic              core_init, core_next, core_keylen;
  logic [255:0]      core_key;
  logic [63:0]       core_iv, core_ctr;
  logic [4:0]        core_rounds;
  logic              core_ready, core_data_out_valid;
  logic [511:0]      core_data_out;

  chacha_stream_ctrl #(.NB_W(NB_W), .ROUNDS(20), .TMO_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .key_in(key_in), .iv_in(iv_in), .ctr_in(ctr_in), .num_blocks(num_blocks),
    .busy(busy), .done(done), .ctr_wrap(ctr_wrap), .err_timeout(err_timeout),
    .ks_data(ks_data), .ks_ctr(ks_ctr), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .core_init(core_init), .core_next(core_next), .core_key(core_key), .core_iv(core_iv),
    .core_ctr(core_ctr), .core_keylen(core_keylen), .core_rounds(core_rounds),
    .core_ready(core_ready), .core_data_out_valid(core_data_out_valid),
    .core_data_out(core_data_out)
  );

  int n_pass = 0;
  int n_total = 0;

  // Keystream block as a pure function of key, nonce and block counter.
  function automatic logic [511:0] mk_block(input logic [255:0] k, input logic [63:0] iv,
                                            input logic [63:0] c);
    logic [127:0] klo;
    klo = k[127:0];
    return {k ^ {4{c}}, iv ^ c, c, ~klo ^ {2{c}}};
  endfunction

  // Consumer ready: fixed level or random
  bit rdy_rand = 0;
  bit rdy_val = 1;
  bit rnd_rdy = 1;
  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end
  assign ks_ready = rdy_rand ? rnd_rdy : rdy_val;

  // chacha_core stand-in: init loads the counter, next increments it, ready low while computing
  int          stub_lat = 3;
  bit          stub_stall = 0;
  int          stub_cnt;
  logic [63:0] stub_ctr;
  always @(posedge clk) begin
    if (!reset_n) begin
      core_ready          <= 1'b1;
      core_data_out_valid <= 1'b0;
      core_data_out       <= '0;
      stub_cnt            <= 0;
      stub_ctr            <= '0;
    end else if (core_init || core_next) begin
      core_ready          <= 1'b0;
      core_data_out_valid <= 1'b0;
      stub_ctr            <= core_init ? core_ctr : stub_ctr + 64'd1;
      stub_cnt            <= stub_lat;
    end else if (!core_ready && !stub_stall) begin
      if (stub_cnt <= 1) begin
        core_ready          <= 1'b1;
        core_data_out_valid <= 1'b1;
        core_data_out       <= mk_block(core_key, core_iv, stub_ctr);
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Event monitor sampled mid-cycle
  int n_init = 0, n_next = 0, n_both = 0, n_done = 0, n_tmo = 0, n_unstable = 0;
  logic [63:0]  cap_ctr[$];
  logic [511:0] cap_data[$];
  bit           hold_prev = 0;
  logic [511:0] prev_data;
  logic [63:0]  prev_ctr;
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_prev = 0;
    end else begin
      if (core_init) n_init++;
      if (core_next) n_next++;
      if (core_init && core_next) n_both++;
      if (done) n_done++;
      if (err_timeout) n_tmo++;
      if (ks_valid && ks_ready) begin
        cap_ctr.push_back(ks_ctr);
        cap_data.push_back(ks_data);
      end
      if (hold_prev && (ks_valid !== 1'b1 || ks_data !== prev_data || ks_ctr !== prev_ctr))
        n_unstable++;
      hold_prev = ks_valid && !ks_ready && !abort;
      prev_data = ks_data;
      prev_ctr  = ks_ctr;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic wait_core_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (core_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic launch(input logic [255:0] k, input logic [63:0] iv, input logic [63:0] c,
                        input int nb);
    key_in = k; iv_in = iv; ctr_in = c; num_blocks = NB_W'(nb);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int base, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_done > base) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (ks_valid !== 1'b0 || done !== 1'b0 || ctr_wrap !== 1'b0 || err_timeout !== 1'b0)
      $display("FAIL reset_flags got v%0b d%0b w%0b t%0b want 0000", ks_valid, done, ctr_wrap, err_timeout);
    else n_pass++;
    n_total++; if (ks_data !== '0 || ks_ctr !== '0 || core_key !== '0 || core_iv !== '0 || core_ctr !== '0)
      $display("FAIL reset_data got nonzero data/ctr/key want 0"); else n_pass++;
    n_total++; if (core_init !== 1'b0 || core_next !== 1'b0 || core_keylen !== 1'b1 || core_rounds !== 5'd20)
      $display("FAIL reset_core got i%0b n%0b kl%0b r%0d want 0 0 1 20", core_init, core_next, core_keylen, core_rounds);
    else n_pass++;
  endtask

  task automatic test_multi_block;
    logic [255:0] k; logic [63:0] iv;
    int b_cap, b_init, b_next, b_done; bit ok;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    iv = {$urandom, $urandom};
    rdy_rand = 0; rdy_val = 1; stub_lat = 3;
    b_cap = cap_ctr.size(); b_init = n_init; b_next = n_next; b_done = n_done;
    wait_core_ready(ok);
    launch(k, iv, 64'd0, 3);
    n_total++; if (busy !== 1'b1 || core_key !== k || core_iv !== iv)
      $display("FAIL mb_latch got busy=%0b key/iv match=%0b want 1 1", busy, core_key === k && core_iv === iv);
    else n_pass++;
    wait_done(500, b_done, ok);
    n_total++; if (!ok) $display("FAIL mb_done_timeout got no done want done"); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mb_busy_after got %0b want 0", busy); else n_pass++;
    step(3);
    n_total++; if (n_init - b_init != 1 || n_next - b_next != 2)
      $display("FAIL mb_pulses got init=%0d next=%0d want 1 2", n_init - b_init, n_next - b_next);
    else n_pass++;
    n_total++; if (cap_ctr.size() - b_cap != 3 || n_done - b_done != 1)
      $display("FAIL mb_count got hs=%0d done=%0d want 3 1", cap_ctr.size() - b_cap, n_done - b_done);
    else n_pass++;
    for (int i = 0; i < 3 && b_cap + i < cap_ctr.size(); i++) begin
      n_total++;
      if (cap_ctr[b_cap+i] !== 64'(i) || cap_data[b_cap+i] !== mk_block(k, iv, 64'(i)))
        $display("FAIL mb_block%0d got ctr=%h want ctr=%h (data match=%0b)", i, cap_ctr[b_cap+i], 64'(i),
                 cap_data[b_cap+i] === mk_block(k, iv, 64'(i)));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    logic [255:0] k; logic [63:0] iv, c;
    int b_cap, b_next, b_done, b_unst; bit ok;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    iv = {$urandom, $urandom}; c = {$urandom, $urandom};
    rdy_rand = 0; rdy_val = 0; stub_lat = 2;
    b_cap = cap_ctr.size(); b_done = n_done; b_unst = n_unstable;
    wait_core_ready(ok);
    launch(k, iv, c, 2);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ks_valid === 1'b1) begin ok = 1; break; end
    end
    n_total++; if (!ok) $display("FAIL bp_valid_timeout got no ks_valid want ks_valid"); else n_pass++;
    b_next = n_next;
    step(40);
    @(negedge clk);
    n_total++; if (ks_valid !== 1'b1 || ks_data !== mk_block(k, iv, c) || ks_ctr !== c)
      $display("FAIL bp_hold got v=%0b ctr=%h want v=1 ctr=%h", ks_valid, ks_ctr, c);
    else n_pass++;
    n_total++; if (n_next != b_next || n_unstable != b_unst)
      $display("FAIL bp_stable got next=%0d unstable=%0d want 0 0", n_next - b_next, n_unstable - b_unst);
    else n_pass++;
    step(1);
    rdy_val = 1;
    wait_done(300, b_done, ok);
    step(2);
    n_total++; if (!ok || cap_ctr.size() - b_cap != 2)
      $display("FAIL bp_done got done=%0b hs=%0d want 1 2", ok, cap_ctr.size() - b_cap);
    else n_pass++;
    if (cap_ctr.size() - b_cap == 2) begin
      n_total++; if (cap_ctr[b_cap+1] !== c + 64'd1 || cap_data[b_cap+1] !== mk_block(k, iv, c + 64'd1))
        $display("FAIL bp_block1 got ctr=%h want %h", cap_ctr[b_cap+1], c + 64'd1);
      else n_pass++;
    end
  endtask

  task automatic test_ctr_wrap;
    logic [255:0] k; logic [63:0] iv, c;
    int b_cap, b_done; bit ok;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    iv = {$urandom, $urandom}; c = 64'hFFFF_FFFF_FFFF_FFFF;
    rdy_rand = 0; rdy_val = 1; stub_lat = 3;
    b_cap = cap_ctr.size(); b_done = n_done;
    wait_core_ready(ok);
    launch(k, iv, c, 2);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cap_ctr.size() > b_cap) begin ok = 1; break; end
    end
    @(negedge clk);
    n_total++; if (!ok || ctr_wrap !== 1'b1)
      $display("FAIL wrap_sticky got hs=%0b wrap=%0b want 1 1", ok, ctr_wrap);
    else n_pass++;
    wait_done(300, b_done, ok);
    step(1);
    n_total++; if (cap_ctr.size() - b_cap != 2) $display("FAIL wrap_count got %0d want 2", cap_ctr.size() - b_cap);
    else n_pass++;
    if (cap_ctr.size() - b_cap == 2) begin
      n_total++; if (cap_ctr[b_cap] !== 64'hFFFF_FFFF_FFFF_FFFF || cap_ctr[b_cap+1] !== 64'd0 ||
                     cap_data[b_cap+1] !== mk_block(k, iv, 64'd0))
        $display("FAIL wrap_ctrs got %h %h want ffffffffffffffff 0", cap_ctr[b_cap], cap_ctr[b_cap+1]);
      else n_pass++;
    end
    b_done = n_done;
    wait_core_ready(ok);
    launch(k, iv, 64'd5, 1);
    @(negedge clk);
    n_total++; if (ctr_wrap !== 1'b0) $display("FAIL wrap_clear got %0b want 0", ctr_wrap); else n_pass++;
    wait_done(300, b_done, ok);
    step(1);
  endtask

  task automatic test_zero_blocks;
    int b_init, b_done; bit ok;
    rdy_rand = 0; rdy_val = 1;
    b_init = n_init; b_done = n_done;
    wait_core_ready(ok);
    launch({8{$urandom}}, 64'd1, 64'd9, 0);
    @(negedge clk);
    n_total++; if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_done got done=%0b busy=%0b want 1 0", done, busy);
    else n_pass++;
    step(5);
    @(negedge clk);
    n_total++; if (done !== 1'b0 || busy !== 1'b0 || n_init != b_init || n_done - b_done != 1)
      $display("FAIL zero_after got done=%0b busy=%0b init=%0d dones=%0d want 0 0 0 1",
               done, busy, n_init - b_init, n_done - b_done);
    else n_pass++;
  endtask

  task automatic test_abort;
    logic [255:0] k; logic [63:0] iv, c;
    int b_cap, b_next, b_done, b_init; bit ok;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    iv = {$urandom, $urandom}; c = {$urandom, $urandom};
    rdy_rand = 0; rdy_val = 1; stub_lat = 6;
    b_cap = cap_ctr.size(); b_next = n_next; b_done = n_done;
    wait_core_ready(ok);
    launch(k, iv, c, 4);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (n_next - b_next == 1 && core_ready === 1'b0) begin ok = 1; break; end
    end
    n_total++; if (!ok) $display("FAIL abort_reach got no block1 wait want block1 wait"); else n_pass++;
    step(1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0 || ks_valid !== 1'b0)
      $display("FAIL abort_idle got busy=%0b v=%0b want 0 0", busy, ks_valid);
    else n_pass++;
    step(15);
    n_total++; if (n_done != b_done || cap_ctr.size() - b_cap != 1 || busy !== 1'b0)
      $display("FAIL abort_quiet got dones=%0d hs=%0d busy=%0b want 0 1 0", n_done - b_done, cap_ctr.size() - b_cap, busy);
    else n_pass++;
    c = {$urandom, $urandom};
    stub_lat = 2; b_cap = cap_ctr.size(); b_init = n_init; b_done = n_done;
    wait_core_ready(ok);
    launch(k, iv, c, 2);
    wait_done(300, b_done, ok);
    step(1);
    n_total++; if (!ok || n_init - b_init != 1 || cap_ctr.size() - b_cap != 2)
      $display("FAIL abort_restart got done=%0b init=%0d hs=%0d want 1 1 2", ok, n_init - b_init, cap_ctr.size() - b_cap);
    else n_pass++;
    if (cap_ctr.size() - b_cap == 2) begin
      n_total++; if (cap_ctr[b_cap] !== c || cap_data[b_cap] !== mk_block(k, iv, c))
        $display("FAIL abort_first got ctr=%h want %h", cap_ctr[b_cap], c);
      else n_pass++;
    end
  endtask

  task automatic test_random_jobs;
    for (int j = 0; j < 8; j++) begin
      logic [255:0] k; logic [63:0] iv, c; logic [64:0] last; logic exp_wrap;
      int nb, b_cap, b_init, b_next, b_done; bit ok;
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      iv = {$urandom, $urandom};
      c = (j % 2 == 1) ? 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 4)) : {$urandom, $urandom};
      nb = $urandom_range(1, 5);
      stub_lat = $urandom_range(1, 5);
      rdy_rand = 1;
      last = {1'b0, c} + 65'(nb - 1);
      exp_wrap = (last >= 65'h0_FFFF_FFFF_FFFF_FFFF);
      b_cap = cap_ctr.size(); b_init = n_init; b_next = n_next; b_done = n_done;
      wait_core_ready(ok);
      launch(k, iv, c, nb);
      wait_done(800, b_done, ok);
      step(1);
      n_total++;
      if (!ok || cap_ctr.size() - b_cap != nb || n_init - b_init != 1 || n_next - b_next != nb - 1)
        $display("FAIL rnd%0d_counts got done=%0b hs=%0d init=%0d next=%0d want 1 %0d 1 %0d",
                 j, ok, cap_ctr.size() - b_cap, n_init - b_init, n_next - b_next, nb, nb - 1);
      else n_pass++;
      for (int i = 0; i < nb && b_cap + i < cap_ctr.size(); i++) begin
        n_total++;
        if (cap_ctr[b_cap+i] !== c + 64'(i) || cap_data[b_cap+i] !== mk_block(k, iv, c + 64'(i)))
          $display("FAIL rnd%0d_block%0d got ctr=%h want %h", j, i, cap_ctr[b_cap+i], c + 64'(i));
        else n_pass++;
      end
      n_total++; if (ctr_wrap !== exp_wrap)
        $display("FAIL rnd%0d_wrap got %0b want %0b", j, ctr_wrap, exp_wrap);
      else n_pass++;
    end
    rdy_rand = 0;
    n_total++; if (n_both != 0) $display("FAIL init_next_overlap got %0d want 0", n_both); else n_pass++;
  endtask

  task automatic test_stall;
    int b_done, b_tmo; bit ok;
    rdy_rand = 0; rdy_val = 1; stub_lat = 2;
    b_done = n_done; b_tmo = n_tmo;
    wait_core_ready(ok);
    stub_stall = 1;
    launch({8{$urandom}}, 64'd3, 64'd7, 1);
    step(40);
    @(negedge clk);
`ifdef CHACHA_CTRL_TIMEOUT_EN
    n_total++; if (n_tmo - b_tmo != 1 || busy !== 1'b0 || n_done != b_done)
      $display("FAIL stall_timeout got tmo=%0d busy=%0b dones=%0d want 1 0 0", n_tmo - b_tmo, busy, n_done - b_done);
    else n_pass++;
`else
    n_total++; if (n_tmo != b_tmo || err_timeout !== 1'b0 || busy !== 1'b1 || n_done != b_done)
      $display("FAIL stall_wait got tmo=%0d busy=%0b dones=%0d want 0 1 0", n_tmo - b_tmo, busy, n_done - b_done);
    else n_pass++;
`endif
    stub_stall = 0;
    do_reset();
  endtask

  task automatic test_reset_mid_hold;
    bit ok;
    rdy_rand = 0; rdy_val = 0; stub_lat = 2;
    wait_core_ready(ok);
    launch({8{$urandom}}, {$urandom, $urandom}, {$urandom, $urandom}, 2);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ks_valid === 1'b1) begin ok = 1; break; end
    end
    step(3);
    reset_n = 1'b0;
    step(1);
    @(negedge clk);
    n_total++;
    if (!ok || ks_valid !== 1'b0 || busy !== 1'b0 || ks_data !== '0 || ks_ctr !== '0 ||
        core_key !== '0 || core_ctr !== '0 || core_rounds !== 5'd20 || core_keylen !== 1'b1)
      $display("FAIL reset_hold got held=%0b v=%0b busy=%0b data0=%0b want 1 0 0 1",
               ok, ks_valid, busy, ks_data === '0);
    else n_pass++;
    reset_n = 1'b1;
    rdy_val = 1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_multi_block();
    test_backpressure();
    test_ctr_wrap();
    test_zero_blocks();
    test_abort();
    test_random_jobs();
    test_stall();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
